reset_req_gen: RTL and testbench



---
 rtl/reset_req_pkg.sv | 31 +++
 rtl/reset_req_gen_if.sv | 30 +++
 rtl/sync2ff.sv | 30 +++
 rtl/reset_req_gen.sv | 143 ++++++++++++++
 tb/tb_reset_req_gen.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/reset_req_pkg.sv
`default_nettype none
// ============================================================================
// Module  : reset_req_pkg
// Brief   : Shared types and constants for the reset-request generator.
// Revision: 1.0
// ============================================================================
package reset_req_pkg;

    localparam int c_count_w = 8;
    localparam int c_cause_w = 3;

    typedef enum logic [1:0] {
        ST_BOOT      = 2'd0,
        ST_RUN       = 2'd1,
        ST_ASSERT    = 2'd2,
        ST_WAIT_LOCK = 2'd3
    } state_t;

    localparam logic [c_cause_w-1:0] CAUSE_NONE      = 3'd0;
    localparam logic [c_cause_w-1:0] CAUSE_LOCK_LOSS = 3'd1;
    localparam logic [c_cause_w-1:0] CAUSE_LOCK_TMO  = 3'd2;
    localparam logic [c_cause_w-1:0] CAUSE_SW        = 3'd3;
    localparam logic [c_cause_w-1:0] CAUSE_WDT       = 3'd4;

    // Bits needed to hold values 0..max_val
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reset_req_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : reset_req_gen_if
// Brief   : Monitor inputs and request/status outputs of reset_req_gen.
// Revision: 1.0
// ============================================================================
interface reset_req_gen_if;
    import reset_req_pkg::*;

    logic                 pll_lock_n;
    logic                 sw_reset_req;
    logic                 wdt_enable;
    logic                 wdt_kick;
    logic                 reset_req_n;
    logic                 busy;
    logic                 lock_ok;
    logic [c_cause_w-1:0] reset_cause;
    logic [c_count_w-1:0] reset_count;

    modport master (
        output pll_lock_n, sw_reset_req, wdt_enable, wdt_kick,
        input  reset_req_n, busy, lock_ok, reset_cause, reset_count
    );

    modport slave (
        input  pll_lock_n, sw_reset_req, wdt_enable, wdt_kick,
        output reset_req_n, busy, lock_ok, reset_cause, reset_count
    );
endinterface
`default_nettype wire

// File: rtl/sync2ff.sv
`default_nettype none
// ============================================================================
// Module  : sync2ff
// Brief   : Two-flop synchroniser, asynchronous active-high reset to RESET_VAL.
// Revision: 1.0
// ============================================================================
module sync2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_d,
    output logic      o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule
`default_nettype wire

// File: rtl/reset_req_gen.sv
`default_nettype none
// ============================================================================
// Module  : reset_req_gen
// Brief   : Issues fixed-width reset request pulses on lock loss, lock timeout,
//           software request or watchdog expiry; records cause and count.
// Revision: 1.0
// ============================================================================
module reset_req_gen
    import reset_req_pkg::*;
#(
    parameter int HOLD_CYCLES  = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int LOSS_FILTER  = 4,
    parameter int WDT_CYCLES   = 1048576
) (
    input  wire logic       clk,
    input  wire logic       reset,
    reset_req_gen_if.slave  bus
);
    localparam int c_tmo_w  = cnt_width(LOCK_TIMEOUT - 1);
    localparam int c_loss_w = cnt_width(LOSS_FILTER - 1);
    localparam int c_wdt_w  = cnt_width(WDT_CYCLES - 1);
    localparam int c_hold_w = cnt_width(HOLD_CYCLES - 1);

    localparam logic [c_tmo_w-1:0]  c_tmo_last  = c_tmo_w'(LOCK_TIMEOUT - 1);
    localparam logic [c_loss_w-1:0] c_loss_last = c_loss_w'(LOSS_FILTER - 1);
    localparam logic [c_wdt_w-1:0]  c_wdt_last  = c_wdt_w'(WDT_CYCLES - 1);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_CYCLES - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_tmo_w-1:0]   r_tmo_cnt;
    logic [c_loss_w-1:0]  r_loss_cnt;
    logic [c_wdt_w-1:0]   r_wdt_cnt;
    logic [c_hold_w-1:0]  r_hold_cnt;
    logic                 r_req_n;
    logic [c_cause_w-1:0] r_cause;
    logic [c_cause_w-1:0] w_cause_nxt;
    logic [c_count_w-1:0] r_count;
    logic                 w_sync_n;
    logic                 w_lock_ok;
    logic                 w_lock_loss;
    logic                 w_wdt_expire;
    logic                 w_enter_assert;

    sync2ff #(.RESET_VAL(1'b1)) u_lock_sync (
        .clk (clk),
        .rst (reset),
        .i_d (bus.pll_lock_n),
        .o_q (w_sync_n)
    );

    assign w_lock_ok = ~w_sync_n;

    // The LOSS_FILTER-th consecutive unlocked sample is the loss event itself
    assign w_lock_loss  = !w_lock_ok && (r_loss_cnt == c_loss_last);
    assign w_wdt_expire = bus.wdt_enable && !bus.wdt_kick && (r_wdt_cnt == c_wdt_last);

    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        case (r_state)
            ST_BOOT, ST_WAIT_LOCK: begin
                if (w_lock_ok) begin
                    w_state_nxt = ST_RUN;
                end else if (r_tmo_cnt == c_tmo_last) begin
                    w_state_nxt = ST_ASSERT;
                    w_cause_nxt = CAUSE_LOCK_TMO;
                end
            end
            ST_RUN: begin
                if (w_lock_loss) begin
                    w_state_nxt = ST_ASSERT;
                    w_cause_nxt = CAUSE_LOCK_LOSS;
                end else if (w_wdt_expire) begin
                    w_state_nxt = ST_ASSERT;
                    w_cause_nxt = CAUSE_WDT;
                end else if (bus.sw_reset_req) begin
                    w_state_nxt = ST_ASSERT;
                    w_cause_nxt = CAUSE_SW;
                end
            end
            ST_ASSERT: begin
                if (r_hold_cnt == c_hold_last) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end
            end
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    assign w_enter_assert = (w_state_nxt == ST_ASSERT) && (r_state != ST_ASSERT);

    // Counters clear whenever their state is left, so each episode starts at 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_BOOT;
            r_tmo_cnt  <= '0;
            r_loss_cnt <= '0;
            r_wdt_cnt  <= '0;
            r_hold_cnt <= '0;
            r_req_n    <= 1'b1;
            r_cause    <= CAUSE_NONE;
            r_count    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_req_n <= (w_state_nxt != ST_ASSERT);

            if ((r_state == ST_BOOT || r_state == ST_WAIT_LOCK) && w_state_nxt == r_state)
                r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
            else
                r_tmo_cnt <= '0;

            if (r_state == ST_RUN && w_state_nxt == ST_RUN && !w_lock_ok)
                r_loss_cnt <= r_loss_cnt + c_loss_w'(1);
            else
                r_loss_cnt <= '0;

            if (r_state == ST_RUN && w_state_nxt == ST_RUN && bus.wdt_enable && !bus.wdt_kick)
                r_wdt_cnt <= r_wdt_cnt + c_wdt_w'(1);
            else
                r_wdt_cnt <= '0;

            if (r_state == ST_ASSERT && w_state_nxt == ST_ASSERT)
                r_hold_cnt <= r_hold_cnt + c_hold_w'(1);
            else
                r_hold_cnt <= '0;

            if (w_enter_assert) begin
                r_cause <= w_cause_nxt;
                if (r_count != {c_count_w{1'b1}})
                    r_count <= r_count + c_count_w'(1);
            end
        end
    end

    assign bus.reset_req_n = r_req_n;
    assign bus.busy        = (r_state != ST_RUN);
    assign bus.lock_ok     = w_lock_ok;
    assign bus.reset_cause = r_cause;
    assign bus.reset_count = r_count;
endmodule
`default_nettype wire

// File: tb/tb_reset_req_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_reset_req_gen
// Brief   : Directed scoreboard bench for reset_req_gen (HOLD=4, TMO=20, LOSS=3, WDT=32).
// Revision: 1.0
// ============================================================================
module tb_reset_req_gen;
    localparam int c_hold = 4;

    typedef struct {
        int cyc;
        int cause;
        int count;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    exp_t exp_q[$];
    logic in_pulse;
    int   pulse_start;

    reset_req_gen_if bus();

    reset_req_gen #(
        .HOLD_CYCLES  (4),
        .LOCK_TIMEOUT (20),
        .LOSS_FILTER  (3),
        .WDT_CYCLES   (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle n is the interval after the n-th rising edge following reset release
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Monitor: each falling edge of reset_req_n consumes one expected request
    always @(negedge clk) begin
        if (reset) begin
            in_pulse = 1'b0;
        end else if (!in_pulse && !bus.reset_req_n) begin
            exp_t e;
            in_pulse    = 1'b1;
            pulse_start = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_req: request at cycle %0d cause %0d count %0d, none expected",
                         cyc, bus.reset_cause, bus.reset_count);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.cause != int'(bus.reset_cause) || e.count != int'(bus.reset_count)) begin
                    errors++;
                    $display("FAIL req: got cycle %0d cause %0d count %0d, expected cycle %0d cause %0d count %0d",
                             cyc, bus.reset_cause, bus.reset_count, e.cyc, e.cause, e.count);
                end
            end
        end else if (in_pulse && bus.reset_req_n) begin
            in_pulse = 1'b0;
            checks++;
            if (cyc - pulse_start != c_hold) begin
                errors++;
                $display("FAIL width: pulse from cycle %0d low %0d cycles, expected %0d",
                         pulse_start, cyc - pulse_start, c_hold);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at_neg(input int n);
        wait_cyc(n);
        @(negedge clk);
    endtask

    task automatic push(input int c, input int cause, input int count);
        exp_t e;
        e.cyc   = c;
        e.cause = cause;
        e.count = count;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input logic lock_n);
        reset            = 1'b1;
        bus.pll_lock_n   = lock_n;
        bus.sw_reset_req = 1'b0;
        bus.wdt_enable   = 1'b0;
        bus.wdt_kick     = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL sim_timeout: bench did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        checks   = 0;
        errors   = 0;
        in_pulse = 1'b0;
        reset    = 1'b1;
        bus.pll_lock_n   = 1'b1;
        bus.sw_reset_req = 1'b0;
        bus.wdt_enable   = 1'b0;
        bus.wdt_kick     = 1'b0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_n", bus.reset_req_n, 1);
        chk("rst_busy",  bus.busy, 1);
        chk("rst_lock",  bus.lock_ok, 0);
        chk("rst_cause", bus.reset_cause, 0);
        chk("rst_count", bus.reset_count, 0);
        do_reset(1'b1);

        // 1: boot lock
        wait_cyc(5);  bus.pll_lock_n = 1'b0;
        at_neg(6);    chk("t1_lock_c6", bus.lock_ok, 0);
        at_neg(7);    chk("t1_lock_c7", bus.lock_ok, 1);
                      chk("t1_busy_c7", bus.busy, 1);
        at_neg(8);    chk("t1_busy_c8", bus.busy, 0);
                      chk("t1_req_n",   bus.reset_req_n, 1);
                      chk("t1_count",   bus.reset_count, 0);

        // 2: short glitch ignored, sustained loss requests
        wait_cyc(10); bus.pll_lock_n = 1'b1;
        wait_cyc(12); bus.pll_lock_n = 1'b0;
        at_neg(14);   chk("t2_glitch_busy", bus.busy, 0);
        push(25, 1, 1);
        wait_cyc(20); bus.pll_lock_n = 1'b1;
        at_neg(27);   chk("t2_req_low", bus.reset_req_n, 0);
                      chk("t2_cause",   bus.reset_cause, 1);
        wait_cyc(30); bus.pll_lock_n = 1'b0;
        at_neg(32);   chk("t2_busy_c32", bus.busy, 1);
        at_neg(33);   chk("t2_busy_c33", bus.busy, 0);
                      chk("t2_pending", exp_q.size(), 0);

        // 3: software request, second pulse during ASSERT dropped
        push(41, 3, 2);
        wait_cyc(40); bus.sw_reset_req = 1'b1;
        wait_cyc(41); bus.sw_reset_req = 1'b0;
        wait_cyc(42); bus.sw_reset_req = 1'b1;
        wait_cyc(43); bus.sw_reset_req = 1'b0;
        at_neg(46);   chk("t3_busy",  bus.busy, 0);
        at_neg(50);   chk("t3_count", bus.reset_count, 2);
                      chk("t3_cause", bus.reset_cause, 3);
                      chk("t3_pending", exp_q.size(), 0);

        // 4: watchdog expiry, then kicks that keep it quiet
        push(82, 4, 3);
        wait_cyc(50); bus.wdt_enable = 1'b1;
        wait_cyc(86); bus.wdt_enable = 1'b0;
        at_neg(87);   chk("t4_busy",  bus.busy, 0);
                      chk("t4_cause", bus.reset_cause, 4);
                      chk("t4_count", bus.reset_count, 3);
        wait_cyc(90); bus.wdt_enable = 1'b1;
        wait_cyc(121); bus.wdt_kick = 1'b1;
        wait_cyc(122); bus.wdt_kick = 1'b0;
        for (int k = 141; k <= 201; k += 20) begin
            wait_cyc(k);     bus.wdt_kick = 1'b1;
            wait_cyc(k + 1); bus.wdt_kick = 1'b0;
        end
        wait_cyc(210); bus.wdt_enable = 1'b0;
        at_neg(240);  chk("t4_count_end", bus.reset_count, 3);
                      chk("t4_busy_end",  bus.busy, 0);
                      chk("t4_pending",   exp_q.size(), 0);

        // 6: simultaneous loss + sw, then async reset mid-ASSERT
        do_reset(1'b1);
        wait_cyc(1);  bus.pll_lock_n = 1'b0;
        at_neg(4);    chk("t6_busy", bus.busy, 0);
        push(15, 1, 1);
        wait_cyc(10); bus.pll_lock_n = 1'b1;
        wait_cyc(14); bus.sw_reset_req = 1'b1;
        wait_cyc(15); bus.sw_reset_req = 1'b0;
        wait_cyc(16); chk("t6_pre_rst_req", bus.reset_req_n, 0);
        reset = 1'b1;
        #1;
        chk("t6_rst_req_n", bus.reset_req_n, 1);
        chk("t6_rst_cause", bus.reset_cause, 0);
        chk("t6_rst_count", bus.reset_count, 0);
        chk("t6_rst_busy",  bus.busy, 1);
        chk("t6_rst_lock",  bus.lock_ok, 0);
        chk("t6_pending",   exp_q.size(), 0);

        // 5: never locks -> periodic timeout requests, count saturates
        do_reset(1'b1);
        for (int i = 1; i <= 258; i++)
            push(20 + 24 * (i - 1), 2, (i > 255) ? 255 : i);
        at_neg(6200);
        chk("t5_pending", exp_q.size(), 0);
        chk("t5_count",   bus.reset_count, 255);
        chk("t5_cause",   bus.reset_cause, 2);
        chk("t5_busy",    bus.busy, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
